pc_flag_unit: RTL
=================

Name: pc_flag_unit

Overview:
- Program-counter and condition-flag stage that sits directly downstream of the 4-bit ALU.
- Registers the ALU's carry/zero outputs into architectural flags and uses them to resolve jumps.
- Produces the instruction-ROM address each cycle.
- Decode logic supplies the jump opcode, target and flag write-enable.

Parameters:
PC_W, 10, width of program counter / ROM address
STACK_DEPTH, 4, return-address entries (used only with CALL_STACK_EN; power of two, >=2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
stall  input  1  1 = hold all state this cycle
op  input  3  000 NEXT, 001 JMP, 010 JZ, 011 JNZ, 100 JC, 101 JNC, 110 CALL, 111 RET
target  input  PC_W  absolute jump/call destination
flags_we  input  1  latch carry_in/zero_in this cycle
carry_in  input  1  ALU carry output
zero_in  input  1  ALU zero output
pc  output  PC_W  current ROM address (registered)
carry_q  output  1  registered carry flag
zero_q  output  1  registered zero flag
taken  output  1  registered; 1 for one cycle after a redirect
stack_err  output  1  sticky stack over/underflow (0 when feature off)

Behaviour:
- Reset (reset=0, async): pc=0, carry_q=0, zero_q=0, taken=0, stack_err=0, stack pointer=0.
- All outputs are registers; update only on rising clk edge with reset=1 and stall=0.
- stall=1: pc, flags, taken, stack contents, pointer and stack_err all hold; op/target ignored.
- Next-pc select:
  - NEXT: pc+1.
  - JMP: target.
  - JZ: target if zero_q=1, else pc+1.
  - JNZ: target if zero_q=0, else pc+1.
  - JC: target if carry_q=1, else pc+1.
  - JNC: target if carry_q=0, else pc+1.
- Condition uses the flag values held before the edge. A same-cycle flags_we does not affect that cycle's jump decision.
- flags_we=1: carry_q<=carry_in, zero_q<=zero_in. Both flags are always written together.
- taken<=1 when the next pc came from target or the stack, else 0. A JMP to pc+1 still sets taken=1.
- pc+1 wraps modulo 2^PC_W: max value -> 0, taken=0.
- Unused combinations (op 110/111 with feature off) behave as NEXT.
- Reset asserted mid-cycle clears state immediately, with no dependence on clk.

Optional Feature:
CALL_STACK_EN
- Defined:
  - A STACK_DEPTH-entry LIFO of PC_W-bit return addresses plus a pointer, range 0..STACK_DEPTH.
  - CALL: push pc+1 (wrapped), pc<=target, taken=1.
  - RET: pop, pc<=popped value, taken=1.
  - CALL when full: no push, pc<=pc+1, taken=0, stack_err<=1.
  - RET when empty: pc<=pc+1, taken=0, stack_err<=1.
  - stack_err is cleared only by reset.
  - Flags are unaffected by CALL/RET except through flags_we.
- Undefined: no stack storage; 110/111 decode as NEXT; stack_err tied 0.

Test Plan:
- Reset then 5 cycles of op=NEXT, stall=0 -> pc sequence 0,1,2,3,4,5; taken=0 throughout; flags 0.
- pc=0x3FF, op=NEXT -> pc=0x000, taken=0.
- Edge A: flags_we=1, zero_in=1, carry_in=0. Edge B: op=JZ, target=0x120 -> pc=0x120, taken=1, zero_q=1. Next edge: op=JNZ, target=0x200 -> pc=0x121, taken=0.
- Flags 0, then op=JC, target=0x050, flags_we=1, carry_in=1 in the same cycle -> pc=prev+1 (not taken), carry_q=1. Following JC -> pc=0x050.
- stall=1 for 3 cycles with op=JMP, target=0x0AA, flags_we=1 -> pc, flags, taken unchanged. Release -> pc=0x0AA, taken=1.
- CALL_STACK_EN, STACK_DEPTH=4:
  - 5 CALLs from pc=0x010 with targets 0x100,0x200,0x300,0x040,0x080 -> 5th call not taken, pc=0x041, stack_err=1.
  - 4 RETs -> pc=0x301,0x201,0x101,0x011.
  - 5th RET -> pc=0x012, stack_err stays 1.

Source files
------------

// File: rtl/pc_flag_unit_if.sv
// Decode/ALU-side bus of the program-counter and flag stage.
// Handshake: there is no valid/ready pair. The stage consumes op/target/flags_we
// on every rising clk edge where stall=0, and stall=1 freezes it completely.
// master = decode/ALU side, slave = pc_flag_unit.
interface pc_flag_unit_if #(
    parameter int PC_W = 10
);
    logic            stall;
    logic [2:0]      op;
    logic [PC_W-1:0] target;
    logic            flags_we;
    logic            carry_in;
    logic            zero_in;
    logic [PC_W-1:0] pc;
    logic            carry_q;
    logic            zero_q;
    logic            taken;
    logic            stack_err;

    modport master (
        output stall, op, target, flags_we, carry_in, zero_in,
        input  pc, carry_q, zero_q, taken, stack_err
    );

    modport slave (
        input  stall, op, target, flags_we, carry_in, zero_in,
        output pc, carry_q, zero_q, taken, stack_err
    );
endinterface

// File: rtl/pc_flag_unit.sv
// Program-counter and condition-flag stage behind the 4-bit ALU.
// Latches the ALU carry/zero into architectural flags, resolves conditional
// jumps against the flags held before the edge, and drives the ROM address.
// Optional return-address stack for CALL/RET is enabled by defining the
// macro CALL_STACK_EN; without it op 110/111 behave as NEXT and stack_err=0.
module pc_flag_unit #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_flag_unit_if.slave bus
);
    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JNZ  = 3'b011;
    localparam logic [2:0] OP_JC   = 3'b100;
    localparam logic [2:0] OP_JNC  = 3'b101;
    localparam logic [2:0] OP_CALL = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;

    // Depth must be a power of two so the pointer's low bits index the LIFO.
    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_flag_unit: STACK_DEPTH must be a power of two >= 2");
    end

    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic            taken_q, taken_d;

`ifdef CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [PC_W-1:0]  stack_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             err_q, err_d;
    logic             push_en;

    assign wr_idx = sp_q[IDX_W-1:0];
    assign rd_idx = wr_idx - IDX_W'(1);
`endif

    assign pc_inc = pc_q + PC_W'(1);

    // Next-state select: pc source, redirect marker, flag capture, stack effects.
    always_comb begin
        pc_d    = pc_inc;
        taken_d = 1'b0;
        carry_d = carry_q;
        zero_d  = zero_q;
`ifdef CALL_STACK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
`endif
        // Flags written here only affect the next cycle's jump decisions.
        if (bus.flags_we) begin
            carry_d = bus.carry_in;
            zero_d  = bus.zero_in;
        end
        case (bus.op)
            OP_JMP: begin
                pc_d    = bus.target;
                taken_d = 1'b1;
            end
            OP_JZ: if (zero_q) begin
                pc_d    = bus.target;
                taken_d = 1'b1;
            end
            OP_JNZ: if (!zero_q) begin
                pc_d    = bus.target;
                taken_d = 1'b1;
            end
            OP_JC: if (carry_q) begin
                pc_d    = bus.target;
                taken_d = 1'b1;
            end
            OP_JNC: if (!carry_q) begin
                pc_d    = bus.target;
                taken_d = 1'b1;
            end
`ifdef CALL_STACK_EN
            OP_CALL: begin
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                    pc_d    = bus.target;
                    taken_d = 1'b1;
                end
            end
            OP_RET: begin
                if (sp_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    sp_d    = sp_q - SP_W'(1);
                    pc_d    = stack_q[rd_idx];
                    taken_d = 1'b1;
                end
            end
`endif
            default: ; // OP_NEXT (and CALL/RET when the stack is absent)
        endcase
    end

    // Architectural pc/flag/taken registers; stall freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            taken_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q    <= pc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            taken_q <= taken_d;
        end
    end

`ifdef CALL_STACK_EN
    // Return-address LIFO, pointer and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (!bus.stall) begin
            sp_q  <= sp_d;
            err_q <= err_d;
            if (push_en) begin
                stack_q[wr_idx] <= pc_inc;
            end
        end
    end

    assign bus.stack_err = err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.pc      = pc_q;
    assign bus.carry_q = carry_q;
    assign bus.zero_q  = zero_q;
    assign bus.taken   = taken_q;
endmodule
